// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock sequencer.
//   lock_state_e : sequencer states
//   CODE_DIGITS  : digits per entry (4), DIGIT_W : bits per digit (4)
//   code_nibble  : returns the digit of a code expected at a given entry position
package lock_pkg;

    localparam int unsigned CODE_DIGITS = 4;
    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned CODE_W      = CODE_DIGITS * DIGIT_W;
    localparam int unsigned COUNT_W     = 3;
    localparam int unsigned FAIL_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKOUT
    } lock_state_e;

    // Digit idx of the code, most-significant nibble first.
    function automatic logic [DIGIT_W-1:0] code_nibble(input logic [CODE_W-1:0] code,
                                                       input logic [COUNT_W-1:0] idx);
        logic [CODE_W-1:0] shifted;
        shifted = code << (DIGIT_W * idx);
        return shifted[CODE_W-1 -: DIGIT_W];
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a registered zero flag.
//   clock, reset : clock, asynchronous active-low reset (count 0, zero 1)
//   load         : load load_value this cycle (takes priority over counting)
//   load_value   : value to load
//   zero         : count is zero
// The counter stops at zero until reloaded.
module lock_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, else decrement until zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count and zero flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            zero    <= 1'b1;
        end else begin
            count_q <= count_d;
            zero    <= (count_d == '0);
        end
    end

endmodule

// File: rtl/lock_sequencer.sv
// Keypad code lock: collects four digits, checks them against a stored code,
// opens for a fixed window on success and locks out after repeated failures.
//   clock, reset  : clock, asynchronous active-low reset
//   digit         : keypad digit, transferred when digit_valid & digit_ready
//   digit_valid   : digit present this cycle
//   digit_ready   : digits accepted (IDLE and COLLECT only)
//   cypher        : replacement code, taken when cypher_load is high in OPEN
//   cypher_load   : request to replace the stored code
//   unlock        : high throughout OPEN
//   alarm         : high throughout LOCKOUT
//   fail_count    : consecutive failed entries
//   digit_count   : digits collected in the current entry
// Build option: define LOCK_SEQ_TIMEOUT_EN to abandon an entry after
// ENTRY_TIMEOUT idle cycles in COLLECT.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned       MAX_TRIES      = 3,
    parameter int unsigned       OPEN_CYCLES    = 16,
    parameter int unsigned       LOCKOUT_CYCLES = 64,
    parameter int unsigned       ENTRY_TIMEOUT  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [CODE_W-1:0]  cypher,
    input  logic               cypher_load,
    output logic               unlock,
    output logic               alarm,
    output logic [FAIL_W-1:0]  fail_count,
    output logic [COUNT_W-1:0] digit_count
);

    // One timer serves every window, so size it for the longest.
    localparam int unsigned WIN_A   = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned WIN_MAX = (WIN_A > ENTRY_TIMEOUT) ? WIN_A : ENTRY_TIMEOUT;
    localparam int unsigned TIMER_W = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

    lock_state_e         state_q;
    lock_state_e         state_d;
    logic [CODE_W-1:0]   code_q;
    logic                mismatch_q;
    logic                mismatch_d;
    logic [COUNT_W-1:0]  digit_count_d;
    logic [FAIL_W-1:0]   fail_count_d;
    logic                unlock_d;
    logic                alarm_d;
    logic                digit_ready_d;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_value;
    logic                timer_zero;
    logic                accept;
    logic                last_digit;
    logic [FAIL_W:0]     tries_next;
    logic                lockout_due;

    assign accept      = digit_valid & digit_ready;
    assign last_digit  = (digit_count == COUNT_W'(CODE_DIGITS - 1));
    assign tries_next  = {1'b0, fail_count} + (FAIL_W + 1)'(1);
    assign lockout_due = (tries_next >= (FAIL_W + 1)'(MAX_TRIES));

    lock_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept && last_digit) begin
                    state_d = ST_CHECK;
                end
`ifdef LOCK_SEQ_TIMEOUT_EN
                else if (!accept && timer_zero) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_CHECK: begin
                if (!mismatch_q) begin
                    state_d = ST_OPEN;
                end else if (lockout_due) begin
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; everything is registered below.
    always_comb begin
        digit_count_d = digit_count;
        fail_count_d  = fail_count;
        mismatch_d    = mismatch_q;
        timer_load    = 1'b0;
        timer_value   = '0;

        unique case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    digit_count_d = digit_count + COUNT_W'(1);
                    mismatch_d    = mismatch_q | (digit != code_nibble(code_q, digit_count));
`ifdef LOCK_SEQ_TIMEOUT_EN
                    // Every accepted digit restarts the idle budget.
                    timer_load    = 1'b1;
                    timer_value   = TIMER_W'(ENTRY_TIMEOUT - 1);
`endif
                end
            end
            ST_CHECK: begin
                digit_count_d = '0;
                if (state_d == ST_OPEN) begin
                    fail_count_d = '0;
                    timer_load   = 1'b1;
                    timer_value  = TIMER_W'(OPEN_CYCLES - 1);
                end else if (state_d == ST_LOCKOUT) begin
                    fail_count_d = FAIL_W'(MAX_TRIES);
                    timer_load   = 1'b1;
                    timer_value  = TIMER_W'(LOCKOUT_CYCLES - 1);
                end else begin
                    fail_count_d = fail_count + FAIL_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (state_d == ST_IDLE) begin
                    fail_count_d = '0;
                end
            end
            default: begin
            end
        endcase

        // Any return to IDLE starts a fresh entry.
        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            mismatch_d    = 1'b0;
            digit_count_d = '0;
        end

        unlock_d      = (state_d == ST_OPEN);
        alarm_d       = (state_d == ST_LOCKOUT);
        digit_ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
    end

    // Registered outputs, entry tracking and stored code.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code_q      <= DEFAULT_CODE;
            mismatch_q  <= 1'b0;
            digit_count <= '0;
            fail_count  <= '0;
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            digit_ready <= 1'b1;
        end else begin
            mismatch_q  <= mismatch_d;
            digit_count <= digit_count_d;
            fail_count  <= fail_count_d;
            unlock      <= unlock_d;
            alarm       <= alarm_d;
            digit_ready <= digit_ready_d;
            if ((state_q == ST_OPEN) && cypher_load) begin
                code_q <= cypher;
            end
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: random and directed code entries, a code-level
// reference model predicting each entry outcome, and a negedge monitor that
// checks outcomes, window lengths and digit counts from a scoreboard.
// Also covers the LOCK_SEQ_TIMEOUT_EN build when that macro is defined.
module tb_lock_sequencer;

    localparam logic [15:0] DEF_CODE  = 16'h1234;
    localparam int          MAX_T     = 3;
    localparam int          OPEN_C    = 16;
    localparam int          LOCK_C    = 64;
    localparam int          TIMEOUT_C = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  digit = '0;
    logic        digit_valid = 1'b0;
    logic        digit_ready;
    logic [15:0] cypher = '0;
    logic        cypher_load = 1'b0;
    logic        unlock;
    logic        alarm;
    logic [1:0]  fail_count;
    logic [2:0]  digit_count;

    lock_sequencer #(
        .DEFAULT_CODE   (DEF_CODE),
        .MAX_TRIES      (MAX_T),
        .OPEN_CYCLES    (OPEN_C),
        .LOCKOUT_CYCLES (LOCK_C),
        .ENTRY_TIMEOUT  (TIMEOUT_C)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .cypher      (cypher),
        .cypher_load (cypher_load),
        .unlock      (unlock),
        .alarm       (alarm),
        .fail_count  (fail_count),
        .digit_count (digit_count)
    );

    always #5 clock = ~clock;

    // kind: 0 = failed entry back to IDLE, 1 = unlock, 2 = lockout
    typedef struct {
        int kind;
        int fail_now;
    } exp_t;

    exp_t        exp_q[$];
    int          dc_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_code = DEF_CODE;
    int          m_fail = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT outputs against scoreboard entries.
    initial begin
        int   prev_dc = 0;
        logic prev_unlock = 1'b0;
        logic prev_alarm = 1'b0;
        int   ulen = 0;
        int   alen = 0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("rst_unlock", int'(unlock), 0);
                check("rst_alarm", int'(alarm), 0);
                check("rst_fail_count", int'(fail_count), 0);
                check("rst_digit_count", int'(digit_count), 0);
                check("rst_digit_ready", int'(digit_ready), 1);
                ulen = 0;
                alen = 0;
                prev_dc = 0;
                prev_unlock = 1'b0;
                prev_alarm = 1'b0;
            end else begin
                if ((int'(digit_count) != prev_dc) && (digit_count != 3'd0)) begin
                    if (dc_q.size() == 0) begin
                        check("unexpected_digit_count", int'(digit_count), -1);
                    end else begin
                        check("digit_count", int'(digit_count), dc_q.pop_front());
                    end
                end
                if ((prev_dc == 4) && (digit_count == 3'd0)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_outcome", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("outcome_unlock", int'(unlock), int'(e.kind == 1));
                        check("outcome_alarm", int'(alarm), int'(e.kind == 2));
                        check("outcome_fail_count", int'(fail_count), e.fail_now);
                    end
                end
                if (unlock) begin
                    ulen++;
                end else if (prev_unlock) begin
                    check("unlock_length", ulen, OPEN_C);
                    ulen = 0;
                end
                if (alarm) begin
                    alen++;
                end else if (prev_alarm) begin
                    check("alarm_length", alen, LOCK_C);
                    check("fail_count_after_lockout", int'(fail_count), 0);
                    alen = 0;
                end
                prev_dc = int'(digit_count);
                prev_unlock = unlock;
                prev_alarm = alarm;
            end
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (!digit_ready && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!digit_ready) check("digit_ready_timeout", 0, 1);
    endtask

    task automatic send_digit(input logic [3:0] d, input int exp_dc);
        wait_ready();
        dc_q.push_back(exp_dc);
        digit = d;
        digit_valid = 1'b1;
        @(posedge clock);
        #1;
        digit_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clock);
        #1;
        reset = 1'b0;
        digit_valid = 1'b0;
        cypher_load = 1'b0;
        m_code = DEF_CODE;
        m_fail = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Enter digits first..3 of val, predict the outcome, optionally load a new
    // code during OPEN and poke digits while the keypad is not ready.
    task automatic do_entry(input logic [15:0] val, input int first, input bit do_load,
                            input logic [15:0] new_code, input bit junk, input bit wait_done);
        exp_t e;
        for (int k = first; k < 4; k++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            send_digit(val[15-4*k -: 4], k + 1);
        end
        if (val == m_code) begin
            e.kind = 1;
            e.fail_now = 0;
            m_fail = 0;
        end else if (m_fail + 1 >= MAX_T) begin
            e.kind = 2;
            e.fail_now = MAX_T;
            m_fail = 0;
        end else begin
            m_fail++;
            e.kind = 0;
            e.fail_now = m_fail;
        end
        exp_q.push_back(e);
        if (e.kind != 0) begin
            @(posedge clock);
            #1;
            if (junk) begin
                digit = 4'($urandom);
                digit_valid = 1'b1;
            end
            @(posedge clock);
            #1;
            if (do_load && e.kind == 1) begin
                cypher = new_code;
                cypher_load = 1'b1;
                m_code = new_code;
            end
            @(posedge clock);
            #1;
            cypher_load = 1'b0;
            digit_valid = 1'b0;
        end
        if (wait_done) wait_ready();
    endtask

    initial begin
        logic [15:0] v;
        reset_dut();

        // Default code unlocks.
        do_entry(16'h1234, 0, 1'b0, 16'h0, 1'b0, 1'b1);
        // Three wrong entries: fail 1, fail 2, lockout.
        repeat (3) do_entry(16'h1235, 0, 1'b0, 16'h0, 1'b1, 1'b1);
        // Change code while open, then old code fails, new one opens.
        do_entry(16'h1234, 0, 1'b1, 16'hA5C3, 1'b1, 1'b1);
        do_entry(16'hA5C3, 0, 1'b0, 16'h0, 1'b0, 1'b1);
        do_entry(16'h1234, 0, 1'b0, 16'h0, 1'b0, 1'b1);
        // Reset restores the default code.
        reset_dut();
        // Load request in IDLE is ignored.
        cypher = 16'hFFFF;
        cypher_load = 1'b1;
        @(posedge clock);
        #1;
        cypher_load = 1'b0;
        do_entry(16'h1234, 0, 1'b0, 16'h0, 1'b0, 1'b1);
        // Reset part-way through an entry.
        send_digit(4'h1, 1);
        send_digit(4'h2, 2);
        reset_dut();
        do_entry(16'h1234, 0, 1'b0, 16'h0, 1'b0, 1'b1);
        // Reset part-way through lockout.
        repeat (2) do_entry(16'h9999, 0, 1'b0, 16'h0, 1'b0, 1'b1);
        do_entry(16'h9999, 0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (30) @(posedge clock);
        #1;
        reset_dut();
        do_entry(16'h1234, 0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Idle gap inside an entry, after one failed entry.
        do_entry(16'h4321, 0, 1'b0, 16'h0, 1'b0, 1'b1);
        send_digit(4'h1, 1);
        send_digit(4'h2, 2);
`ifdef LOCK_SEQ_TIMEOUT_EN
        repeat (TIMEOUT_C) @(posedge clock);
        #1;
        check("timeout_digit_count", int'(digit_count), 0);
        check("timeout_fail_count", int'(fail_count), m_fail);
        check("timeout_ready", int'(digit_ready), 1);
        do_entry(16'h1234, 0, 1'b0, 16'h0, 1'b0, 1'b1);
`else
        repeat (TIMEOUT_C + 8) @(posedge clock);
        #1;
        check("no_timeout_digit_count", int'(digit_count), 2);
        do_entry(16'h1234, 2, 1'b0, 16'h0, 1'b0, 1'b1);
`endif

        // Random entries against the model.
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                cypher = 16'($urandom);
                cypher_load = 1'b1;
                @(posedge clock);
                #1;
                cypher_load = 1'b0;
            end
            if (r <= 1) begin
                v = m_code;
            end else if (r == 2) begin
                v = 16'($urandom);
            end else begin
                v = m_code;
                v[4*$urandom_range(0, 3) +: 4] ^= 4'($urandom_range(1, 15));
            end
            do_entry(v, 0, ($urandom_range(0, 2) == 0), 16'($urandom),
                     ($urandom_range(0, 1) == 1), 1'b1);
        end

        repeat (4) @(posedge clock);
        #1;
        check("outcomes_left", exp_q.size(), 0);
        check("digit_counts_left", dc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameter DEFAULT_CODE, default 16'h1234, stored code after reset.
REQ-002 Parameter MAX_TRIES, default 3, consecutive failed entries that trigger lockout; legal range 1..3.
REQ-003 Parameter OPEN_CYCLES, default 16, length of the unlock window in clocks; must be at least 1.
REQ-004 Parameter LOCKOUT_CYCLES, default 64, length of the alarm/lockout window in clocks; must be at least 1.
REQ-005 Parameter ENTRY_TIMEOUT, default 32, max idle clocks between digits; used only under the configuration macro.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  reset, asynchronous, active-low.
REQ-008 digit  input  4  keypad digit.
REQ-009 digit_valid  input  1  digit present this cycle.
REQ-010 digit_ready  output  1  block accepts a digit this cycle; a digit transfers when digit_valid & digit_ready.
REQ-011 cypher  input  16  new code.
REQ-012 cypher_load  input  1  request to replace the stored code.
REQ-013 unlock  output  1  high throughout OPEN.
REQ-014 alarm  output  1  high throughout LOCKOUT.
REQ-015 fail_count  output  2  consecutive failed entries.
REQ-016 digit_count  output  3  digits collected in the current entry, 0..4.

Function
REQ-017 States SHALL be IDLE, COLLECT, CHECK, OPEN and LOCKOUT.
REQ-018 digit_ready SHALL be 1 in IDLE and COLLECT and 0 in all other states; it depends on state only.
REQ-019 Digits SHALL be entered most-significant nibble first: accepted digit k (k = 0..3) is compared with code[15-4k -: 4].
REQ-020 Any nibble mismatch SHALL set a sticky mismatch flag, cleared on entry to IDLE.
REQ-021 An accepted digit in IDLE SHALL move to COLLECT with digit_count=1.
REQ-022 Each accepted digit in COLLECT SHALL increment digit_count.
REQ-023 Acceptance of the 4th digit SHALL move to CHECK on the next clock.
REQ-024 CHECK SHALL last exactly 1 cycle.
REQ-025 On CHECK with no mismatch: go to OPEN, clear fail_count, set digit_count=0.
REQ-026 On CHECK with a mismatch and fail_count+1 < MAX_TRIES: increment fail_count and go to IDLE.
REQ-027 On CHECK with a mismatch and fail_count+1 = MAX_TRIES: set fail_count=MAX_TRIES and go to LOCKOUT.
REQ-028 unlock SHALL rise the cycle after CHECK and stay high exactly OPEN_CYCLES cycles, then the block returns to IDLE.
REQ-029 alarm SHALL stay high exactly LOCKOUT_CYCLES cycles; on exit fail_count clears and the block goes to IDLE.
REQ-030 cypher_load SHALL be honoured only in OPEN; the stored code updates on that clock edge; it is ignored in every other state.
REQ-031 cypher_load SHALL NOT extend or shorten the OPEN window.
REQ-032 digit_valid while digit_ready=0 SHALL be ignored, with no state or counter change.
REQ-033 fail_count SHALL saturate and never wrap.

Reset
REQ-034 On reset assertion, mid-operation included, the block SHALL immediately enter IDLE with: unlock=0, alarm=0, fail_count=0, digit_count=0, mismatch flag clear, timer 0, stored code=DEFAULT_CODE.
REQ-035 A reset during OPEN or LOCKOUT SHALL abort the window with no residual pulse.

Configuration
REQ-036 The entry timeout SHALL be enabled when the macro LOCK_SEQ_TIMEOUT_EN is defined.
REQ-037 With LOCK_SEQ_TIMEOUT_EN defined: in COLLECT, ENTRY_TIMEOUT consecutive cycles with no accepted digit SHALL discard the entry and return to IDLE, with digit_count=0 and fail_count unchanged.
REQ-038 Without LOCK_SEQ_TIMEOUT_EN: COLLECT SHALL wait indefinitely, and the ENTRY_TIMEOUT parameter has no effect.

Structure
REQ-039 Shared package lock_pkg SHALL hold the state enum, CODE_DIGITS=4 and DIGIT_W=4.
REQ-040 One sub-module, lock_timer, SHALL provide a loadable down-counter with a zero flag, shared by OPEN, LOCKOUT and the timeout.

Verification
REQ-041 Default code: enter 1,2,3,4 -> unlock high for 16 cycles starting the cycle after CHECK; fail_count=0.
REQ-042 Enter 1,2,3,5 three times -> fail_count goes 1, then 2, then alarm high for 64 cycles; fail_count=0 afterwards.
REQ-043 Unlock with 1,2,3,4, then pulse cypher_load with 16'hA5C3 during OPEN -> after the window, A,5,C,3 unlocks and 1,2,3,4 fails.
REQ-044 cypher_load 16'hFFFF in IDLE, then enter 1,2,3,4 -> unlock.
REQ-045 Assert reset after 2 digits, or midway through LOCKOUT -> all outputs 0 at once, then 1,2,3,4 unlocks.
REQ-046 With LOCK_SEQ_TIMEOUT_EN defined: enter 1,2, idle 32 cycles -> back in IDLE, digit_count=0, fail_count unchanged, and a following 1,2,3,4 unlocks.
